// File: rtl/score_pkg.sv
// Shared constants, FSM state type and 7-segment encoding for the score display.
// Used by score_bcd_display and seg7_decode.
package score_pkg;

    localparam int unsigned SCORE_W = 11;
    localparam int unsigned DIGITS  = 4;
    localparam int unsigned BCD_W   = DIGITS * 4;
    localparam int unsigned SHIFT_W = BCD_W + SCORE_W;
    localparam int unsigned ITER_W  = $clog2(SCORE_W);

    typedef enum logic {
        IDLE,
        CONV
    } conv_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low segments {g,f,e,d,c,b,a}; non-decimal nibbles show blank.
    function automatic logic [6:0] seg7(input logic [3:0] digit);
        logic [6:0] seg;
        unique case (digit)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low 7-segment decoder with a blank override.
// One instance drives one HEX display.
module seg7_decode
    import score_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    assign seg = blank ? SEG_BLANK : seg7(digit);

endmodule

// File: rtl/score_bcd_display.sv
// Sequential double-dabble score converter driving four blanked 7-segment displays.
// Define SCORE_HISCORE_EN to add the high-score register and start-screen display.
module score_bcd_display
    import score_pkg::*;
(
    input  logic               frame_clk,
    input  logic               Reset_n,
    input  logic [SCORE_W-1:0] totalscore,
    input  logic               ready,
    input  logic               lost,
    output logic [BCD_W-1:0]   bcd,
    output logic               bcd_valid,
    output logic               busy,
    output logic [SCORE_W-1:0] hiscore,
    output logic [6:0]         hex0,
    output logic [6:0]         hex1,
    output logic [6:0]         hex2,
    output logic [6:0]         hex3
);

    logic [SCORE_W-1:0] src;

`ifdef SCORE_HISCORE_EN
    logic               lost_q;
    logic [SCORE_W-1:0] hiscore_q;

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            lost_q    <= 1'b0;
            hiscore_q <= '0;
        end else begin
            lost_q <= lost;
            if (lost && !lost_q && (totalscore > hiscore_q)) begin
                hiscore_q <= totalscore;
            end
        end
    end

    // Start screen (neither playing nor lost) shows the best score instead.
    assign src     = (!ready && !lost) ? hiscore_q : totalscore;
    assign hiscore = hiscore_q;
`else
    logic unused_flags;

    assign unused_flags = ready ^ lost;
    assign src          = totalscore;
    assign hiscore      = '0;
`endif

    conv_state_t        state_q, state_d;
    logic [SCORE_W-1:0] latched_q, latched_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [ITER_W-1:0]  iter_q, iter_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [SHIFT_W-1:0] adj;
    logic [SHIFT_W-1:0] shifted;

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            latched_q <= '0;
            shift_q   <= '0;
            iter_q    <= '0;
            bcd_q     <= '0;
        end else begin
            state_q   <= state_d;
            latched_q <= latched_d;
            shift_q   <= shift_d;
            iter_q    <= iter_d;
            bcd_q     <= bcd_d;
        end
    end

    // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
    always_comb begin
        adj = shift_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (shift_q[SCORE_W + 4*i +: 4] >= 4'd5) begin
                adj[SCORE_W + 4*i +: 4] = shift_q[SCORE_W + 4*i +: 4] + 4'd3;
            end
        end
        shifted = SHIFT_W'({adj, 1'b0});
    end

    always_comb begin
        state_d   = state_q;
        latched_d = latched_q;
        shift_d   = shift_q;
        iter_d    = iter_q;
        bcd_d     = bcd_q;
        unique case (state_q)
            IDLE: begin
                if (src != latched_q) begin
                    latched_d = src;
                    shift_d   = {{BCD_W{1'b0}}, src};
                    iter_d    = '0;
                    state_d   = CONV;
                end
            end
            CONV: begin
                shift_d = shifted;
                if (iter_q == ITER_W'(SCORE_W - 1)) begin
                    bcd_d   = shifted[SHIFT_W-1 -: BCD_W];
                    state_d = IDLE;
                end else begin
                    iter_d = iter_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bcd       = bcd_q;
    assign busy      = (state_q == CONV);
    assign bcd_valid = (state_q == IDLE);

    // Blank each digit while it and every digit above it are zero; ones digit always shows.
    logic [DIGITS-1:0] blank;
    logic              zero_run;

    always_comb begin
        blank    = '0;
        zero_run = 1'b1;
        for (int i = int'(DIGITS) - 1; i > 0; i--) begin
            zero_run = zero_run && (bcd_q[4*i +: 4] == 4'd0);
            blank[i] = zero_run;
        end
    end

    logic [6:0] seg [DIGITS];

    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_digit
        seg7_decode u_seg7_decode (
            .digit (bcd_q[4*g +: 4]),
            .blank (blank[g]),
            .seg   (seg[g])
        );
    end

    assign hex0 = seg[0];
    assign hex1 = seg[1];
    assign hex2 = seg[2];
    assign hex3 = seg[3];

endmodule
